// File: rtl/fir_cplx_pkg.sv
// Shared types and helpers for the complex decimating FIR: FSM state, accumulator sizing, output clamp.
package fir_cplx_pkg;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      MAC   = 2'd1,
      WRITE = 2'd2
   } state_t;

   // Working width of the clamp helper; every accumulator must fit inside it.
   localparam int SAT_W = 128;

   // Two full-width products per tap plus growth over the tap sum: no intermediate truncation.
   function automatic int acc_width(input int data_w, input int coeff_w, input int taps);
      return data_w + coeff_w + $clog2(taps) + 1;
   endfunction

   function automatic logic signed [SAT_W-1:0] sat_trunc(input logic signed [SAT_W-1:0] v,
                                                          input int unsigned dw);
      logic signed [SAT_W-1:0] one;
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      one = SAT_W'(1);
      hi  = (one <<< (dw - 1)) - one;
      lo  = -hi - one;
      if (v > hi) begin
         return hi;
      end
      if (v < lo) begin
         return lo;
      end
      return v;
   endfunction

endpackage

// File: rtl/cplx_mac.sv
// Registered complex multiply-accumulate: acc += h * x with full-precision products and a
// synchronous clear that takes priority over enable.
module cplx_mac
   import fir_cplx_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int COEFF_WIDTH = 32,
   parameter int ACC_WIDTH   = acc_width(32, 32, 20)
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          acc_clr,
   input  logic                          acc_en,
   input  logic signed [DATA_WIDTH-1:0]  x_re,
   input  logic signed [DATA_WIDTH-1:0]  x_im,
   input  logic signed [COEFF_WIDTH-1:0] h_re,
   input  logic signed [COEFF_WIDTH-1:0] h_im,
   output logic signed [ACC_WIDTH-1:0]   acc_re,
   output logic signed [ACC_WIDTH-1:0]   acc_im
);
   localparam int PW = DATA_WIDTH + COEFF_WIDTH;

   logic signed [PW-1:0] p_rr;
   logic signed [PW-1:0] p_ii;
   logic signed [PW-1:0] p_ri;
   logic signed [PW-1:0] p_ir;

   assign p_rr = PW'(x_re) * PW'(h_re);
   assign p_ii = PW'(x_im) * PW'(h_im);
   assign p_ri = PW'(x_im) * PW'(h_re);
   assign p_ir = PW'(x_re) * PW'(h_im);

   always_ff @(posedge clock) begin
      if (reset || acc_clr) begin
         acc_re <= '0;
         acc_im <= '0;
      end else if (acc_en) begin
         acc_re <= acc_re + ACC_WIDTH'(p_rr) - ACC_WIDTH'(p_ii);
         acc_im <= acc_im + ACC_WIDTH'(p_ri) + ACC_WIDTH'(p_ir);
      end
   end

endmodule

// File: rtl/fir_cplx_decim.sv
// Complex-coefficient FIR with integer decimation: I/Q FIFO handshakes, sample ring, FSM, one complex MAC.
// Build option: define FIR_CPLX_SATURATE_EN to clamp results and add the sticky sat_seen output.
//
// state | meaning
// FILL  | pop I/Q pairs into the ring until a decimation group is complete
// MAC   | one tap per cycle for TAP_NUMBER cycles, h[0] against the newest sample
// WRITE | push the rescaled result once both output FIFOs have room
module fir_cplx_decim
   import fir_cplx_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int COEFF_WIDTH = 32,
   parameter int FRAC_BITS   = 10,
   parameter int TAP_NUMBER  = 20,
   parameter int DECIMATION  = 1,
   parameter logic [TAP_NUMBER-1:0][COEFF_WIDTH-1:0] REAL_COEFF = '0,
   parameter logic [TAP_NUMBER-1:0][COEFF_WIDTH-1:0] IMAG_COEFF = '0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] i_in,
   input  logic                  i_empty,
   output logic                  i_rd_en,
   input  logic [DATA_WIDTH-1:0] q_in,
   input  logic                  q_empty,
   output logic                  q_rd_en,
   output logic [DATA_WIDTH-1:0] real_out,
   output logic                  real_wr_en,
   input  logic                  real_full,
   output logic [DATA_WIDTH-1:0] imag_out,
   output logic                  imag_wr_en,
   input  logic                  imag_full
`ifdef FIR_CPLX_SATURATE_EN
   ,
   output logic                  sat_seen
`endif
);
   localparam int ACC_WIDTH = acc_width(DATA_WIDTH, COEFF_WIDTH, TAP_NUMBER);
   localparam int PTR_W     = $clog2(TAP_NUMBER);
   localparam int CNT_W     = $clog2(TAP_NUMBER + 1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(TAP_NUMBER - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIMATION - 1);

   state_t state_q;
   state_t state_d;

   logic [PTR_W-1:0] wp;
   logic [PTR_W-1:0] k;
   logic [PTR_W-1:0] rd_idx;
   logic [CNT_W-1:0] cnt;

   logic pop;
   logic push;
   logic acc_clr;
   logic acc_en;

   logic signed [DATA_WIDTH-1:0]  smp_re [TAP_NUMBER];
   logic signed [DATA_WIDTH-1:0]  smp_im [TAP_NUMBER];
   logic signed [DATA_WIDTH-1:0]  x_re;
   logic signed [DATA_WIDTH-1:0]  x_im;
   logic signed [COEFF_WIDTH-1:0] tap_re;
   logic signed [COEFF_WIDTH-1:0] tap_im;
   logic signed [ACC_WIDTH-1:0]   acc_re;
   logic signed [ACC_WIDTH-1:0]   acc_im;
   logic [DATA_WIDTH-1:0]         res_re;
   logic [DATA_WIDTH-1:0]         res_im;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= FILL;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      push    = 1'b0;
      acc_clr = 1'b0;
      acc_en  = 1'b0;
      case (state_q)
         FILL: begin
            if (!i_empty && !q_empty) begin
               pop = 1'b1;
               if (cnt == CNT_LAST) begin
                  acc_clr = 1'b1;
                  state_d = MAC;
               end
            end
         end
         MAC: begin
            acc_en = 1'b1;
            if (k == PTR_LAST) begin
               state_d = WRITE;
            end
         end
         WRITE: begin
            if (!real_full && !imag_full) begin
               push    = 1'b1;
               state_d = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wp  <= '0;
         cnt <= '0;
         k   <= '0;
      end else begin
         if (pop) begin
            wp <= (wp == PTR_LAST) ? '0 : wp + 1'b1;
            if (cnt != CNT_LAST) begin
               cnt <= cnt + 1'b1;
            end
         end
         if (push) begin
            cnt <= '0;
         end
         if (acc_clr) begin
            k <= '0;
         end else if (acc_en) begin
            k <= (k == PTR_LAST) ? '0 : k + 1'b1;
         end
      end
   end

   // Cleared on reset so history from before the reset contributes zeros.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < TAP_NUMBER; i++) begin
            smp_re[i] <= '0;
            smp_im[i] <= '0;
         end
      end else if (pop) begin
         smp_re[wp] <= i_in;
         smp_im[wp] <= q_in;
      end
   end

   // wp already points past the newest sample, so tap k reads (wp - 1 - k) mod TAP_NUMBER.
   always_comb begin
      int idx;
      idx = int'(wp) - 1 - int'(k);
      if (idx < 0) begin
         idx = idx + TAP_NUMBER;
      end
      rd_idx = PTR_W'(idx);
   end

   assign x_re   = smp_re[rd_idx];
   assign x_im   = smp_im[rd_idx];
   assign tap_re = REAL_COEFF[k];
   assign tap_im = IMAG_COEFF[k];

   cplx_mac #(
      .DATA_WIDTH  (DATA_WIDTH),
      .COEFF_WIDTH (COEFF_WIDTH),
      .ACC_WIDTH   (ACC_WIDTH)
   ) u_mac (
      .clock   (clock),
      .reset   (reset),
      .acc_clr (acc_clr),
      .acc_en  (acc_en),
      .x_re    (x_re),
      .x_im    (x_im),
      .h_re    (tap_re),
      .h_im    (tap_im),
      .acc_re  (acc_re),
      .acc_im  (acc_im)
   );

`ifdef FIR_CPLX_SATURATE_EN
   logic signed [SAT_W-1:0] wide_re;
   logic signed [SAT_W-1:0] wide_im;
   logic signed [SAT_W-1:0] clip_re;
   logic signed [SAT_W-1:0] clip_im;
   logic                    sat_now;

   always_comb begin
      wide_re = SAT_W'(acc_re >>> FRAC_BITS);
      wide_im = SAT_W'(acc_im >>> FRAC_BITS);
      clip_re = sat_trunc(wide_re, DATA_WIDTH);
      clip_im = sat_trunc(wide_im, DATA_WIDTH);
      res_re  = DATA_WIDTH'(clip_re);
      res_im  = DATA_WIDTH'(clip_im);
      sat_now = (clip_re != wide_re) || (clip_im != wide_im);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sat_seen <= 1'b0;
      end else if (push && sat_now) begin
         sat_seen <= 1'b1;
      end
   end
`else
   assign res_re = DATA_WIDTH'(acc_re >>> FRAC_BITS);
   assign res_im = DATA_WIDTH'(acc_im >>> FRAC_BITS);
`endif

   // Strobes and data are forced idle while reset is held, even before the first reset edge.
   assign i_rd_en    = pop && !reset;
   assign q_rd_en    = pop && !reset;
   assign real_wr_en = push && !reset;
   assign imag_wr_en = push && !reset;
   assign real_out   = (push && !reset) ? res_re : '0;
   assign imag_out   = (push && !reset) ? res_im : '0;

endmodule
